// File: rtl/ahb_to_apb_bridge.sv
// AHB3-Lite slave to APB4 master bridge: one APB SETUP+ACCESS per accepted AHB beat,
// with APB errors, illegal sizes and APB timeouts reported as the two-cycle AHB ERROR.
module ahb_to_apb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    ahb_hsel,
    input  logic [ADDR_WIDTH-1:0]   ahb_haddr,
    input  logic [1:0]              ahb_htrans,
    input  logic                    ahb_hwrite,
    input  logic [2:0]              ahb_hsize,
    input  logic [DATA_WIDTH-1:0]   ahb_hwdata,
    input  logic                    ahb_hready,
    output logic                    ahb_hreadyout,
    output logic                    ahb_hresp,
    output logic [DATA_WIDTH-1:0]   ahb_hrdata,
    output logic                    apb_psel,
    output logic                    apb_penable,
    output logic [ADDR_WIDTH-1:0]   apb_paddr,
    output logic                    apb_pwrite,
    output logic [DATA_WIDTH-1:0]   apb_pwdata,
    output logic [DATA_WIDTH/8-1:0] apb_pstrb,
    input  logic [DATA_WIDTH-1:0]   apb_prdata,
    input  logic                    apb_pready,
    input  logic                    apb_pslverr
);

    localparam int         STRB_W   = DATA_WIDTH / 8;
    localparam logic [2:0] MAX_SIZE = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;
    localparam int         CNT_W    = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2} state_t;

    state_t           state;
    logic [2:0]       size_q;
    logic [CNT_W-1:0] tcount;
    logic             accept;
    logic             timeout_hit;

    function automatic logic size_bad(input logic [2:0] size, input logic [2:0] lsb);
        logic [2:0] mask;
        if (size > MAX_SIZE) return 1'b1;
        mask = 3'((4'd1 << size[1:0]) - 4'd1);
        return |(lsb & mask);
    endfunction

    // Contiguous 2^size byte lanes starting at the address offset within the bus word.
    function automatic logic [STRB_W-1:0] strb_for(input logic [2:0] size, input logic [2:0] lsb);
        logic [15:0] ones;
        logic [15:0] shifted;
        logic [2:0]  off;
        ones    = (16'd1 << (5'd1 << size[1:0])) - 16'd1;
        off     = lsb & 3'(STRB_W - 1);
        shifted = ones << off;
        return shifted[STRB_W-1:0];
    endfunction

    assign accept = ahb_hsel & ahb_htrans[1] & ahb_hready & ahb_hreadyout &
                    ((state == IDLE) | (state == DONE) | (state == ERR2));
    assign timeout_hit = (TIMEOUT != 0) && (tcount == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            size_q        <= '0;
            tcount        <= '0;
            ahb_hreadyout <= 1'b1;
            ahb_hresp     <= 1'b0;
            ahb_hrdata    <= '0;
            apb_psel      <= 1'b0;
            apb_penable   <= 1'b0;
            apb_paddr     <= '0;
            apb_pwrite    <= 1'b0;
            apb_pwdata    <= '0;
            apb_pstrb     <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR2: begin
                    if (accept) begin
                        size_q        <= ahb_hsize;
                        ahb_hreadyout <= 1'b0;
                        if (size_bad(ahb_hsize, ahb_haddr[2:0])) begin
                            state     <= ERR1;
                            ahb_hresp <= 1'b1;
                        end else begin
                            ahb_hresp  <= 1'b0;
                            apb_paddr  <= ahb_haddr;
                            apb_pwrite <= ahb_hwrite;
                            if (ahb_hwrite) begin
                                state <= WDATA;
                            end else begin
                                state     <= SETUP;
                                apb_psel  <= 1'b1;
                                apb_pstrb <= '0;
                            end
                        end
                    end else begin
                        state         <= IDLE;
                        ahb_hreadyout <= 1'b1;
                        ahb_hresp     <= 1'b0;
                    end
                end
                WDATA: begin
                    apb_pwdata <= ahb_hwdata;
                    apb_pstrb  <= strb_for(size_q, apb_paddr[2:0]);
                    apb_psel   <= 1'b1;
                    state      <= SETUP;
                end
                SETUP: begin
                    apb_penable <= 1'b1;
                    tcount      <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (apb_pready) begin
                        apb_psel    <= 1'b0;
                        apb_penable <= 1'b0;
                        if (apb_pslverr) begin
                            state     <= ERR1;
                            ahb_hresp <= 1'b1;
                        end else begin
                            if (!apb_pwrite) ahb_hrdata <= apb_prdata;
                            state         <= DONE;
                            ahb_hreadyout <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        // Slave is abandoned; the AHB master sees an ERROR instead of a hang.
                        apb_psel    <= 1'b0;
                        apb_penable <= 1'b0;
                        state       <= ERR1;
                        ahb_hresp   <= 1'b1;
                    end else if (tcount != '1) begin
                        tcount <= tcount + CNT_W'(1);
                    end
                end
                ERR1: begin
                    state         <= ERR2;
                    ahb_hreadyout <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    ahb_hreadyout <= 1'b1;
                    ahb_hresp     <= 1'b0;
                end
            endcase
        end
    end

endmodule
